// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//   Drives every input combination 0..2**N_IN-1 (ascending) into a
//   combinational logic block. Each vector is held for SETTLE cycles, and then
//   the block's outputs are captured into a packed truth-table vector.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a sweep (ignored while busy)
//   abort        synchronous cancel; has priority over start
//   dut_out      outputs of the logic block under sweep
//   drv_in       registered inputs applied to the logic block
//   busy         high while a sweep is in progress
//   done         one-cycle pulse after the final vector is sampled
//   table_valid  high from done until the next accepted start or abort
//   table_out    slot j = table_out[j*N_OUT +: N_OUT] = dut_out for input j
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [N_OUT-1:0]              dut_out,
  output logic [N_IN-1:0]               drv_in,
  output logic                          busy,
  output logic                          done,
  output logic                          table_valid,
  output logic [(2**N_IN)*N_OUT-1:0]    table_out
);

  localparam int              N_VEC      = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX   = N_IN'(N_VEC - 1);
  // SETTLE is at most 255, so an 8-bit hold counter always suffices.
  localparam logic [7:0]      CNT_RELOAD = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [N_IN-1:0] idx_r;
  logic [7:0]      cnt_r;

  // Sweep controller: sequencing, sampling, and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      cnt_r       <= 8'd0;
      drv_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
      table_out   <= '0;
    end else begin
      // done is a pulse: it is cleared on every edge unless set below.
      done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          // DONE behaves exactly like IDLE for accepting a new sweep.
          if (abort) begin
            table_valid <= 1'b0;
          end else if (start) begin
            drv_in      <= '0;
            idx_r       <= '0;
            cnt_r       <= CNT_RELOAD;
            busy        <= 1'b1;
            table_valid <= 1'b0;
            table_out   <= '0;
            state_r     <= WAIT;
          end else begin
            state_r <= state_r;
          end
        end
        WAIT: begin
          if (abort) begin
            // Any partial table is left in place but not marked valid.
            state_r     <= IDLE;
            busy        <= 1'b0;
            drv_in      <= '0;
            table_valid <= 1'b0;
          end else if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else begin
            table_out[int'(idx_r)*N_OUT +: N_OUT] <= dut_out;
            if (idx_r != LAST_IDX) begin
              idx_r  <= idx_r + N_IN'(1);
              drv_in <= idx_r + N_IN'(1);
              cnt_r  <= CNT_RELOAD;
            end else begin
              busy        <= 1'b0;
              done        <= 1'b1;
              table_valid <= 1'b1;
              state_r     <= DONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          drv_in  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//   Directed bench for truth_table_sweeper. Instance a uses SETTLE=4, and
//   instance b uses SETTLE=1. Each instance drives a small logic block that
//   maps inputs 0..7 to outputs 7,6,4,5,1,0,2,3.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  localparam logic [23:0] FULL_TABLE = 24'h681B37;
  // Slots 0..2 after sampling vectors 0,1,2 (outputs 7,6,4).
  localparam logic [23:0] PART_TABLE = 24'h000137;

  logic        clk;
  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic [2:0]  dut_out_a, dut_out_b, drv_in_a, drv_in_b;
  logic        busy_a, done_a, table_valid_a;
  logic        busy_b, done_b, table_valid_b;
  logic [23:0] table_out_a, table_out_b;

  int errors = 0;
  int checks = 0;

  function automatic logic [2:0] logic_block(input logic [2:0] x);
    case (x)
      3'd0:    logic_block = 3'd7;
      3'd1:    logic_block = 3'd6;
      3'd2:    logic_block = 3'd4;
      3'd3:    logic_block = 3'd5;
      3'd4:    logic_block = 3'd1;
      3'd5:    logic_block = 3'd0;
      3'd6:    logic_block = 3'd2;
      3'd7:    logic_block = 3'd3;
      default: logic_block = 3'bxxx;
    endcase
  endfunction

  assign dut_out_a = logic_block(drv_in_a);
  assign dut_out_b = logic_block(drv_in_b);

  truth_table_sweeper #(.N_IN(3), .N_OUT(3), .SETTLE(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .dut_out(dut_out_a), .drv_in(drv_in_a), .busy(busy_a), .done(done_a),
    .table_valid(table_valid_a), .table_out(table_out_a)
  );

  truth_table_sweeper #(.N_IN(3), .N_OUT(3), .SETTLE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .dut_out(dut_out_b), .drv_in(drv_in_b), .busy(busy_b), .done(done_b),
    .table_valid(table_valid_b), .table_out(table_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run a sweep on instance a, starting at edge 0. The task drives start at
  // edges restart_at and start2_at, and abort at edge abort_at (-1 = never).
  // It observes for n_edges edges.
  task automatic run_a(input int restart_at, input int abort_at, input int start2_at,
                       input int n_edges, output int done_edge, output int busy_cnt,
                       output int done_cnt);
    done_edge = -1;
    busy_cnt  = 0;
    done_cnt  = 0;
    start_a   = 1'b1;
    tick();
    start_a   = 1'b0;
    check("start_clear_tbl", table_out_a, 24'h0);
    check("start_clear_vld", table_valid_a, 1'b0);
    for (int t = 0; t <= n_edges; t++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_cnt++;
        done_edge = t;
      end
      if ((abort_at < 0 || t < abort_at) && t < 32 && (t % 4) == 0)
        check("drv_step", drv_in_a, t / 4);
      if (t == abort_at) begin
        check("abort_busy", busy_a, 1'b0);
        check("abort_drv", drv_in_a, 3'd0);
        check("abort_partial", table_out_a, PART_TABLE);
        check("abort_valid", table_valid_a, 1'b0);
      end
      if (t == start2_at) begin
        check("restart_tbl", table_out_a, 24'h0);
        check("restart_busy", busy_a, 1'b1);
      end
      start_a = (t + 1 == restart_at) || (t + 1 == start2_at);
      abort_a = (t + 1 == abort_at);
      tick();
    end
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  initial begin
    int de, bc, dc;
    rst_n   = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    #12;
    check("rst_drv", drv_in_a, 3'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_valid", table_valid_a, 1'b0);
    check("rst_table", table_out_a, 24'h0);
    rst_n = 1'b1;
    tick();

    // Full sweep with SETTLE=4.
    run_a(-1, -1, -1, 40, de, bc, dc);
    check("full_done_edge", de, 32);
    check("full_done_cnt", dc, 1);
    check("full_busy_cnt", bc, 32);
    check("full_table", table_out_a, FULL_TABLE);
    check("full_valid", table_valid_a, 1'b1);

    // SETTLE=1: a new vector is applied every cycle.
    begin
      int de_b = -1;
      int bc_b = 0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int t = 0; t <= 12; t++) begin
        if (busy_b) bc_b++;
        if (done_b) de_b = t;
        if (t < 8) check("s1_drv", drv_in_b, t);
        tick();
      end
      check("s1_done_edge", de_b, 8);
      check("s1_busy_cnt", bc_b, 8);
      check("s1_table", table_out_b, FULL_TABLE);
      check("s1_valid", table_valid_b, 1'b1);
    end

    // start re-pulsed during a sweep is ignored.
    run_a(10, -1, -1, 40, de, bc, dc);
    check("restart_ign_edge", de, 32);
    check("restart_ign_busy", bc, 32);
    check("restart_ign_tbl", table_out_a, FULL_TABLE);

    // Abort at edge 13, then a clean sweep started at edge 20.
    run_a(-1, 13, 20, 58, de, bc, dc);
    check("abort_done_edge", de, 52);
    check("abort_done_cnt", dc, 1);
    check("abort_busy_cnt", bc, 13 + 32);
    check("abort_re_table", table_out_a, FULL_TABLE);
    check("abort_re_valid", table_valid_a, 1'b1);

    // In DONE, abort together with start: abort wins and no sweep begins.
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    check("both_valid", table_valid_a, 1'b0);
    check("both_busy", busy_a, 1'b0);
    check("both_table", table_out_a, FULL_TABLE);
    check("both_drv", drv_in_a, 3'd7);
    repeat (3) tick();
    check("both_idle_busy", busy_a, 1'b0);
    check("both_idle_done", done_a, 1'b0);
    // start alone launches a fresh sweep.
    run_a(-1, -1, -1, 36, de, bc, dc);
    check("after_both_edge", de, 32);
    check("after_both_tbl", table_out_a, FULL_TABLE);

    // Asynchronous reset asserted mid-sweep and mid-cycle.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (10) tick();
    check("pre_rst_busy", busy_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_drv", drv_in_a, 3'd0);
    check("arst_busy", busy_a, 1'b0);
    check("arst_valid_b", table_valid_b, 1'b0);
    check("arst_table_a", table_out_a, 24'h0);
    check("arst_table_b", table_out_b, 24'h0);
    repeat (3) tick();
    check("arst_hold_done", done_a, 1'b0);
    rst_n = 1'b1;
    repeat (30) tick();
    check("arst_no_done", done_a, 1'b0);
    check("arst_idle_busy", busy_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
